// File: rtl/rv_muldiv_seq.sv
// Multi-cycle RISC-V M-extension unit: radix-2^MUL_STEP shift-add multiplier
// and restoring divider behind valid/ready handshakes with flush.
module rv_muldiv_seq #(
  parameter int XLEN         = 32,
  parameter int MUL_STEP     = 1,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_CALC | one multiply/divide iteration per cycle, cnt counts down
  // S_FIX  | sign correction and result select, registers o_result
  // S_DONE | o_valid held until the consumer accepts
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_N1 = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_N1 = CW'(XLEN - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        funct_q;
  logic [XLEN-1:0]   a_q, spec_res_q, rem_q, quo_q, dvs_q, mplier;
  logic              b_neg_q, neg_q_q, neg_r_q, spec_q;
  logic [2*XLEN-1:0] mcand, acc, step_add;

  logic            accept, is_div, s1_sgn, s2_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  assign accept   = (state == S_IDLE) && i_valid && !i_flush;
  assign is_div   = i_funct[2];
  assign s1_sgn   = is_div ? !i_funct[0] : (i_funct[1:0] != 2'b11);
  assign s2_sgn   = is_div ? !i_funct[0] : (i_funct[1:0] == 2'b01);
  assign a_neg    = s1_sgn && i_rs1[XLEN-1];
  assign b_neg    = s2_sgn && i_rs2[XLEN-1];
  assign a_mag    = a_neg ? -i_rs1 : i_rs1;
  assign b_mag    = b_neg ? -i_rs2 : i_rs2;
  assign div_zero = (i_rs2 == '0);
  assign div_ovf  = !i_funct[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2);
  assign special  = is_div && (div_zero || div_ovf);
  assign spec_val = i_funct[1] ? (div_zero ? i_rs1 : '0) : (div_zero ? '1 : i_rs1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (special && FAST_SPECIAL != 0) ? S_DONE : S_CALC;
      S_CALC: if (i_flush) state_nxt = S_IDLE;
              else if (cnt == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = i_flush ? S_IDLE : S_DONE;
      S_DONE: if (i_flush || i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_ready = (state == S_IDLE);
  assign o_busy  = (state != S_IDLE);
  assign o_valid = (state == S_DONE);

  // Multiplier step: add the shifted multiplicand for each retired multiplier bit.
  always_comb begin
    step_add = '0;
    for (int k = 0; k < MUL_STEP; k++)
      if (mplier[k]) step_add = step_add + (mcand << k);
  end

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff_lo;
  logic            ge;
  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign diff_lo = rem_sh[XLEN-1:0] - dvs_q;

  // High half of an unsigned-rs2 product needs rs1 subtracted when rs2 was negative.
  logic [XLEN-1:0] mul_hi, quo_fix, rem_fix, fix_res;
  always_comb begin
    mul_hi  = acc[2*XLEN-1:XLEN] - (b_neg_q ? a_q : '0);
    quo_fix = neg_q_q ? -quo_q : quo_q;
    rem_fix = neg_r_q ? -rem_q : rem_q;
    fix_res = '0;
    if (spec_q)            fix_res = spec_res_q;
    else if (funct_q[2])   fix_res = funct_q[1] ? rem_fix : quo_fix;
    else if (funct_q == 3'b000) fix_res = acc[XLEN-1:0];
    else                   fix_res = mul_hi;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0; funct_q <= '0; a_q <= '0; spec_res_q <= '0;
      b_neg_q <= 1'b0; neg_q_q <= 1'b0; neg_r_q <= 1'b0; spec_q <= 1'b0;
      mcand <= '0; mplier <= '0; acc <= '0;
      rem_q <= '0; quo_q <= '0; dvs_q <= '0;
      o_result <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          funct_q    <= i_funct;
          a_q        <= i_rs1;
          b_neg_q    <= b_neg;
          neg_q_q    <= a_neg ^ b_neg;
          neg_r_q    <= a_neg;
          spec_q     <= special;
          spec_res_q <= spec_val;
          mcand      <= s1_sgn ? {{XLEN{i_rs1[XLEN-1]}}, i_rs1} : {{XLEN{1'b0}}, i_rs1};
          mplier     <= i_rs2;
          acc        <= '0;
          rem_q      <= '0;
          quo_q      <= a_mag;
          dvs_q      <= b_mag;
          cnt        <= is_div ? DIV_N1 : MUL_N1;
          if (special && FAST_SPECIAL != 0) o_result <= spec_val;
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (funct_q[2]) begin
            rem_q <= ge ? diff_lo : rem_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
          end else begin
            acc    <= acc + step_add;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
          end
        end
        S_FIX: o_result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Self-checking bench: two instances (MUL_STEP=1/FAST_SPECIAL=1 and
// MUL_STEP=4/FAST_SPECIAL=0) driven in lockstep, checked against a plain-arithmetic model.
module tb_rv_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, i_valid, i_flush, i_ready;
  logic [2:0]  i_funct;
  logic [31:0] i_rs1, i_rs2;
  logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
  logic [31:0] res1, res4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_muldiv_seq #(.XLEN(32), .MUL_STEP(1), .FAST_SPECIAL(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy1),
    .i_funct(i_funct), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
    .o_valid(vld1), .i_ready(i_ready), .o_result(res1), .o_busy(busy1));

  rv_muldiv_seq #(.XLEN(32), .MUL_STEP(4), .FAST_SPECIAL(0)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy4),
    .i_funct(i_funct), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
    .o_valid(vld4), .i_ready(i_ready), .o_result(res4), .o_busy(busy4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    p = '0;
    case (f)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >> 32;
      3'd2: p = (sa * ub) >> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: if (b == 0) p = '1; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'b0, a}; else p = sa / sb;
      3'd5: if (b == 0) p = '1; else p = ua / ub;
      3'd6: if (b == 0) p = {32'b0, a}; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0; else p = sa % sb;
      default: if (b == 0) p = {32'b0, a}; else p = ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat1(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic int ref_lat4(input logic [2:0] f);
    return f[2] ? 34 : 10;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat1, input int lat4, input string tag);
    bit got1 = 0, got4 = 0, rdy_ok = 1;
    int l1 = 0, l4 = 0;
    logic [31:0] r1 = '0, r4 = '0;
    @(negedge clk);
    i_funct = f; i_rs1 = a; i_rs2 = b; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0; i_rs1 = $urandom; i_rs2 = $urandom; i_funct = 3'($urandom);
    for (int c = 1; c <= 60 && !(got1 && got4); c++) begin
      @(negedge clk);
      if (!got1) begin
        if (vld1) begin got1 = 1; l1 = c; r1 = res1; end
        else if (rdy1) rdy_ok = 0;
      end
      if (!got4) begin
        if (vld4) begin got4 = 1; l4 = c; r4 = res4; end
        else if (rdy4) rdy_ok = 0;
      end
    end
    chk({tag, "/res1"}, r1, exp);
    chk({tag, "/res4"}, r4, exp);
    chk({tag, "/lat1"}, l1, lat1);
    chk({tag, "/lat4"}, l4, lat4);
    chk({tag, "/ready_low"}, rdy_ok, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bit seen, stable;
    int sel;

    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_funct = '0; i_rs1 = '0; i_rs2 = '0;
    #12;
    chk("rst/valid", {vld1, vld4}, 2'b00);
    chk("rst/result", {res1, res4}, 64'h0);
    chk("rst/busy", {busy1, busy4}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst/ready", {rdy1, rdy4}, 2'b11);

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 10, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 10, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 10, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 10, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 34, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 34, "rem");
    run_op(3'd5, 32'd100,       32'd7,         32'd14,        34, 34, "divu");
    run_op(3'd7, 32'd100,       32'd7,         32'd2,         34, 34, "remu");
    run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, 34, "divu0");
    run_op(3'd6, 32'd5,         32'd0,         32'd5,          1, 34, "rem0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, 34, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1, 34, "rem_ovf");

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      run_op(f, a, b, ref_res(f, a, b), ref_lat1(f, a, b), ref_lat4(f), "rand");
    end

    // Flush while idle with a valid request: nothing is accepted.
    @(negedge clk); i_funct = 3'd5; i_rs1 = 32'd9; i_rs2 = 32'd3; i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1 chk("idle_flush/busy", {busy1, busy4}, 2'b00);
    i_valid = 1'b0; i_flush = 1'b0;

    // Backpressure in DONE.
    @(negedge clk); i_funct = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1 i_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin @(negedge clk); seen = vld1 && vld4; end
    chk("bp/valid_seen", seen, 1);
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(vld1 && vld4 && res1 == 32'd14 && res4 == 32'd14 && !rdy1)) stable = 0;
    end
    chk("bp/stable", stable, 1);
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp/valid_drop", {vld1, vld4}, 2'b00);
    chk("bp/ready", {rdy1, rdy4}, 2'b11);

    // Flush at CALC count 5 (27 edges after accept).
    @(negedge clk); i_funct = 3'd5; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 27; c++) begin @(negedge clk); if (vld1 || vld4) seen = 1; end
    i_flush = 1'b1;
    @(posedge clk); #1;
    chk("flush/busy", {busy1, busy4}, 2'b00);
    chk("flush/ready", {rdy1, rdy4}, 2'b11);
    i_flush = 1'b0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (vld1 || vld4) seen = 1; end
    chk("flush/no_valid", seen, 0);
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 34, 34, "after_flush");

    // Asynchronous reset mid-CALC.
    @(negedge clk); i_funct = 3'd0; i_rs1 = 32'd11; i_rs2 = 32'd13; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst/valid", {vld1, vld4}, 2'b00);
    chk("arst/result", {res1, res4}, 64'h0);
    chk("arst/busy", {busy1, busy4}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    f = 3'd1; a = $urandom; b = $urandom;
    run_op(f, a, b, ref_res(f, a, b), 34, 10, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_seq.md
Name: rv_muldiv_seq

Overview:
- Parametrised multi-cycle RISC-V M-extension execution unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in EX. The ALU decoder routes R-type ops with the mul flag set here, together with funct3 and both operands.
- Uses a radix-2^MUL_STEP shift-add multiplier and a restoring divider.
- Valid/ready handshake on both input and output, plus a flush.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- MUL_STEP, 1, multiplier bits retired per cycle; must be 1, 2 or 4, and must divide XLEN.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_funct  in  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1  in  XLEN  operand A (multiplicand / dividend).
- i_rs2  in  XLEN  operand B (multiplier / divisor).
- i_flush  in  1  abort any in-flight op; the result is discarded.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  result.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_valid=0, o_result=0, o_busy=0, o_ready=1 once reset deasserts.
  - Reset mid-operation discards the op immediately.
- States:
  - IDLE: o_ready=1.
    - On i_valid&o_ready, latch funct and operands, then go to CALC, or directly to DONE for a special case.
  - CALC: one iteration per cycle; counter counts down from N−1.
    - MUL ops: N = XLEN/MUL_STEP.
    - DIV ops: N = XLEN.
    - At count 0, go to FIX.
  - FIX: apply sign correction and select the low or high half, or the quotient or remainder. Register o_result, then go to DONE.
  - DONE: o_valid=1, o_result stable.
    - On i_ready, go to IDLE.
    - o_valid and o_result hold until accepted.
- Latency, measured from the accept edge to the first cycle o_valid is high: N+2 edges. With XLEN=32 this is MUL_STEP=1 → 34, MUL_STEP=4 → 10, DIV → 34.
- No back-to-back accept: the next request is accepted at the earliest one cycle after the DONE handshake.
- Arithmetic:
  - Operands are sign-extended to XLEN+1 bits per op signedness: MULH both signed, MULHSU rs1 signed / rs2 unsigned, MULHU/DIVU/REMU unsigned.
  - Multiply forms a 2·XLEN product. MUL returns the low half; the others return the high half.
  - Divide runs on magnitudes. The quotient is negated if the signs differ (signed ops). The remainder takes the sign of the dividend.
- Special cases:
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed DIV/REM of MIN by −1: quotient = MIN; remainder = 0.
  - FAST_SPECIAL=1: IDLE→DONE directly; o_valid is high after the 1st edge.
  - FAST_SPECIAL=0: the op iterates normally and still yields the values above.
- i_flush:
  - In CALC/FIX/DONE: go to IDLE next edge; o_valid deasserts that edge; no result is delivered.
  - In IDLE with i_valid: the flush wins and no accept occurs.
- i_valid while not ready is ignored; the requester must hold it.
- Operand inputs may change freely after accept.

Test Plan:
- Reset release, then MUL 7 × 0xFFFFFFFD (−3), MUL_STEP=1 → o_valid exactly 34 cycles after accept, o_result=0xFFFFFFEB; o_ready=0 throughout.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; repeat with MUL_STEP=4 → same values, latency 10.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0; all with 1-cycle latency when FAST_SPECIAL=1.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → o_valid and o_result stable; i_ready=1 → IDLE next edge, o_ready=1.
- Flush at CALC count 5 → o_valid never asserts, IDLE next edge; new DIVU 9/3 accepted → 3. Async reset mid-CALC → outputs 0 immediately.
